mcu_frame_scheduler: RTL

// - Sequences sensor frames into the MCU SPI slave.
// - Sits between the BNO085 controller (quat/gyro valid pulses) and mcu_spi_slave.
// - Merges quat+gyro samples into one frame and freezes that frame while the MCU reads it.
// - Runs the done/load handshake, enforces a minimum frame interval, and abandons frames the MCU never acks.

---
 rtl/mcu_link_pkg.sv | 19 +
 rtl/mcu_frame_scheduler_sync_edge_det.sv | 28 ++
 rtl/mcu_frame_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_link_pkg.sv
// Shared types and constants for the MCU frame link: scheduler state encoding,
// frame flag bit positions and the frame header byte.
package mcu_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      PRESENT,
      XFER,
      GAP
   } state_t;

   localparam int FLG_QUAT = 0;
   localparam int FLG_GYRO = 1;
   localparam int FLG_TMO  = 2;

   localparam logic [7:0] HEADER_BYTE = 8'hAA;

endpackage

// File: rtl/mcu_frame_scheduler_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, followed by one delay
// stage so single-cycle rise and fall pulses can be produced in the clk domain.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/mcu_frame_scheduler.sv
// Merges quaternion/gyro samples into one frozen frame for the MCU SPI slave,
// runs the load handshake, abandons unacknowledged frames and rate-limits output.
module mcu_frame_scheduler
   import mcu_link_pkg::*;
#(
   parameter int MERGE_WINDOW = 3000,
   parameter int ACK_TIMEOUT  = 300000,
   parameter int MIN_GAP      = 30000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               quat_valid,
   input  logic signed [15:0] quat_w,
   input  logic signed [15:0] quat_x,
   input  logic signed [15:0] quat_y,
   input  logic signed [15:0] quat_z,
   input  logic               gyro_valid,
   input  logic signed [15:0] gyro_x,
   input  logic signed [15:0] gyro_y,
   input  logic signed [15:0] gyro_z,
   input  logic               load,
   output logic               frame_ready,
   output logic signed [15:0] f_quat_w,
   output logic signed [15:0] f_quat_x,
   output logic signed [15:0] f_quat_y,
   output logic signed [15:0] f_quat_z,
   output logic signed [15:0] f_gyro_x,
   output logic signed [15:0] f_gyro_y,
   output logic signed [15:0] f_gyro_z,
   output logic [7:0]         f_flags,
   output logic [7:0]         f_seq,
   output logic [15:0]        drop_cnt,
   output logic [7:0]         timeout_cnt
);

   localparam int CNT_MAX_A = (MERGE_WINDOW > MIN_GAP) ? MERGE_WINDOW : MIN_GAP;
   localparam int CNT_MAX   = (ACK_TIMEOUT > CNT_MAX_A) ? ACK_TIMEOUT : CNT_MAX_A;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t MERGE_LAST = cnt_t'(MERGE_WINDOW - 1);
   localparam cnt_t ACK_LAST   = cnt_t'(ACK_TIMEOUT - 1);
   localparam cnt_t GAP_LAST   = cnt_t'(MIN_GAP - 1);

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   state_t state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   logic   copy, tmo_hit, acked;
   logic   ack_rise, ack_fall;

   logic               pend_quat_q, pend_gyro_q;
   logic signed [15:0] st_qw_q, st_qx_q, st_qy_q, st_qz_q;
   logic signed [15:0] st_gx_q, st_gy_q, st_gz_q;
   logic signed [15:0] f_qw_q, f_qx_q, f_qy_q, f_qz_q;
   logic signed [15:0] f_gx_q, f_gy_q, f_gz_q;
   logic [1:0]         fresh_q;
   logic               tmo_flag_q;
   logic [7:0]         seq_q, tmo_cnt_q;
   logic [15:0]        drop_q;
   logic [1:0]         drop_inc;

   sync_edge_det u_load_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(load),
      .rise_o (ack_rise),
      .fall_o (ack_fall)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      copy    = 1'b0;
      tmo_hit = 1'b0;
      acked   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_quat_q | pend_gyro_q) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end
         end
         COLLECT: begin
            if ((pend_quat_q & pend_gyro_q) || cnt_q == MERGE_LAST) begin
               state_d = PRESENT;
               cnt_d   = '0;
               copy    = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         PRESENT: begin
            // An ack arriving on the timeout cycle takes priority over abandoning the frame.
            if (ack_rise) begin
               state_d = XFER;
               acked   = 1'b1;
            end else if (cnt_q == ACK_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
               tmo_hit = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         XFER: begin
            if (ack_fall) begin
               state_d = GAP;
               cnt_d   = '0;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A sample arriving in the copy cycle is not a drop: the pending one is being consumed.
   assign drop_inc = {1'b0, quat_valid & pend_quat_q & ~copy}
                   + {1'b0, gyro_valid & pend_gyro_q & ~copy};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_quat_q <= 1'b0;
         pend_gyro_q <= 1'b0;
         st_qw_q     <= '0;
         st_qx_q     <= '0;
         st_qy_q     <= '0;
         st_qz_q     <= '0;
         st_gx_q     <= '0;
         st_gy_q     <= '0;
         st_gz_q     <= '0;
         f_qw_q      <= '0;
         f_qx_q      <= '0;
         f_qy_q      <= '0;
         f_qz_q      <= '0;
         f_gx_q      <= '0;
         f_gy_q      <= '0;
         f_gz_q      <= '0;
         fresh_q     <= '0;
         tmo_flag_q  <= 1'b0;
         seq_q       <= '0;
         tmo_cnt_q   <= '0;
         drop_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= sat_add16(drop_q, drop_inc);

         if (quat_valid) begin
            st_qw_q     <= quat_w;
            st_qx_q     <= quat_x;
            st_qy_q     <= quat_y;
            st_qz_q     <= quat_z;
            pend_quat_q <= 1'b1;
         end else if (copy) begin
            pend_quat_q <= 1'b0;
         end

         if (gyro_valid) begin
            st_gx_q     <= gyro_x;
            st_gy_q     <= gyro_y;
            st_gz_q     <= gyro_z;
            pend_gyro_q <= 1'b1;
         end else if (copy) begin
            pend_gyro_q <= 1'b0;
         end

         if (copy) begin
            f_qw_q            <= st_qw_q;
            f_qx_q            <= st_qx_q;
            f_qy_q            <= st_qy_q;
            f_qz_q            <= st_qz_q;
            f_gx_q            <= st_gx_q;
            f_gy_q            <= st_gy_q;
            f_gz_q            <= st_gz_q;
            fresh_q[FLG_QUAT] <= pend_quat_q;
            fresh_q[FLG_GYRO] <= pend_gyro_q;
            seq_q             <= seq_q + 8'd1;
         end

         if (tmo_hit) begin
            tmo_flag_q <= 1'b1;
            if (tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
         end else if (acked) begin
            tmo_flag_q <= 1'b0;
         end
      end
   end

   always_comb begin
      f_flags           = '0;
      f_flags[FLG_QUAT] = fresh_q[FLG_QUAT];
      f_flags[FLG_GYRO] = fresh_q[FLG_GYRO];
      f_flags[FLG_TMO]  = tmo_flag_q;
   end

   assign frame_ready = (state_q == PRESENT);
   assign f_quat_w    = f_qw_q;
   assign f_quat_x    = f_qx_q;
   assign f_quat_y    = f_qy_q;
   assign f_quat_z    = f_qz_q;
   assign f_gyro_x    = f_gx_q;
   assign f_gyro_y    = f_gy_q;
   assign f_gyro_z    = f_gz_q;
   assign f_seq       = seq_q;
   assign drop_cnt    = drop_q;
   assign timeout_cnt = tmo_cnt_q;

endmodule
